// File: rtl/par2ser_lane.sv
// rtl/par2ser_lane.sv - per-lane byte FIFO and MSB-first serializer with COM/IDL fill
// Sends a COM burst after reset, then queued bytes or IDL, one bit per clock.

module par2ser_lane #(
    parameter int          FIFO_DEPTH     = 4,
    parameter logic [7:0]  COM            = 8'hBC,
    parameter logic [7:0]  IDL            = 8'h7C,
    parameter int          SYNC_COM_COUNT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in,
    input  logic       valid_in,
    output logic       ready,
    output logic       data_out,
    output logic       symbol_start,
    output logic       valid_out,
    output logic       overflow
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int SW = (SYNC_COM_COUNT > 1) ? $clog2(SYNC_COM_COUNT) : 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [SW-1:0] LAST_COM = SW'(SYNC_COM_COUNT - 1);

    typedef enum logic [1:0] {
        ST_RESET,
        ST_SYNC,
        ST_ACTIVE
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [SW-1:0] com_cnt_q, com_cnt_d;
    logic          sym_start_q, sym_start_d;
    logic          valid_out_q, valid_out_d;
    logic          ready_q, ready_d;
    logic          overflow_q, overflow_d;
    logic          push;
    logic          pop;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        com_cnt_d   = com_cnt_q;
        sym_start_d = sym_start_q;
        valid_out_d = valid_out_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        pop         = 1'b0;
        // ready_q already mirrors (count < depth) outside the RESET state
        push        = valid_in & ready_q;
        overflow_d  = overflow_q | (valid_in & ~ready_q);

        case (state_q)
            ST_RESET: begin
                state_d     = ST_SYNC;
                shift_d     = COM;
                bit_cnt_d   = 3'd0;
                com_cnt_d   = '0;
                sym_start_d = 1'b1;
                valid_out_d = 1'b0;
            end
            default: begin
                if (bit_cnt_q == 3'd7) begin
                    bit_cnt_d   = 3'd0;
                    sym_start_d = 1'b1;
                    if (state_q == ST_SYNC && com_cnt_q != LAST_COM) begin
                        shift_d     = COM;
                        valid_out_d = 1'b0;
                        com_cnt_d   = com_cnt_q + SW'(1);
                    end else begin
                        // The boundary after the last COM already serves the FIFO
                        state_d = ST_ACTIVE;
                        if (count_q != '0) begin
                            pop         = 1'b1;
                            shift_d     = mem_q[rd_ptr_q];
                            valid_out_d = 1'b1;
                        end else begin
                            shift_d     = IDL;
                            valid_out_d = 1'b0;
                        end
                    end
                end else begin
                    shift_d     = {shift_q[6:0], 1'b0};
                    bit_cnt_d   = bit_cnt_q + 3'd1;
                    sym_start_d = 1'b0;
                end
            end
        endcase

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        ready_d = (count_d < DEPTH_C);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RESET;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            shift_q     <= 8'h00;
            bit_cnt_q   <= 3'd0;
            com_cnt_q   <= '0;
            sym_start_q <= 1'b0;
            valid_out_q <= 1'b0;
            ready_q     <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            com_cnt_q   <= com_cnt_d;
            sym_start_q <= sym_start_d;
            valid_out_q <= valid_out_d;
            ready_q     <= ready_d;
            overflow_q  <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem_q[wr_ptr_q] <= in;
        end
    end

    assign data_out     = shift_q[7];
    assign symbol_start = sym_start_q;
    assign valid_out    = valid_out_q;
    assign ready        = ready_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_par2ser_lane.sv
// tb/tb_par2ser_lane.sv - self-checking bench for par2ser_lane
// Symbol-stream reference model, vector table, directed corner cases and random traffic.

module tb_par2ser_lane;

    localparam int         DEPTH = 4;
    localparam int         NSYNC = 4;
    localparam logic [7:0] K_COM = 8'hBC;
    localparam logic [7:0] K_IDL = 8'h7C;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] din = 8'h00;
    logic       valid_in = 1'b0;
    logic       ready, data_out, symbol_start, valid_out, overflow;

    par2ser_lane #(
        .FIFO_DEPTH(DEPTH), .COM(K_COM), .IDL(K_IDL), .SYNC_COM_COUNT(NSYNC)
    ) dut (
        .clk(clk), .reset(reset), .in(din), .valid_in(valid_in),
        .ready(ready), .data_out(data_out), .symbol_start(symbol_start),
        .valid_out(valid_out), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: position in the symbol stream is plain cycle arithmetic
    logic       m_rst = 1'b1;
    int         m_t = 0;
    logic [7:0] m_q[$];
    logic [7:0] m_sym = 8'h00;
    logic       m_data = 1'b0;
    logic       m_ovf = 1'b0;
    logic [4:0] m_exp = 5'b0;

    logic [7:0] cap_b[$];
    logic       cap_v[$];
    logic [7:0] cur_b = 8'h00;
    logic       cur_v = 1'b0;
    int         cur_n = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: actual 0x%0h required 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic model_step(input logic rst, input logic v, input logic [7:0] d);
        logic pre_ready;
        int   pos;
        if (rst) begin
            m_rst = 1'b1;
            m_q.delete();
            m_ovf = 1'b0;
            m_exp = 5'b0;
        end else begin
            pre_ready = !m_rst && (m_q.size() < DEPTH);
            if (m_rst) begin
                m_rst  = 1'b0;
                m_t    = 0;
                m_sym  = K_COM;
                m_data = 1'b0;
            end else begin
                m_t++;
                if (m_t % 8 == 0) begin
                    if (m_t / 8 < NSYNC) begin
                        m_sym  = K_COM;
                        m_data = 1'b0;
                    end else if (m_q.size() > 0) begin
                        m_sym  = m_q.pop_front();
                        m_data = 1'b1;
                    end else begin
                        m_sym  = K_IDL;
                        m_data = 1'b0;
                    end
                end
            end
            if (v) begin
                if (pre_ready) m_q.push_back(d);
                else m_ovf = 1'b1;
            end
            pos   = m_t % 8;
            m_exp = {m_sym[7-pos], (pos == 0), m_data, (m_q.size() < DEPTH), m_ovf};
        end
    endtask

    task automatic cyc(input logic rst, input logic v, input logic [7:0] d);
        reset    = rst;
        valid_in = v;
        din      = d;
        @(posedge clk);
        model_step(rst, v, d);
        #1;
        chk("cycle", {data_out, symbol_start, valid_out, ready, overflow}, m_exp);
        if (rst) begin
            cap_b.delete();
            cap_v.delete();
            cur_n = 0;
        end else if (symbol_start) begin
            cur_b = {7'b0, data_out};
            cur_v = valid_out;
            cur_n = 1;
        end else if (cur_n > 0) begin
            cur_b = {cur_b[6:0], data_out};
            cur_n++;
        end
        if (cur_n == 8) begin
            cap_b.push_back(cur_b);
            cap_v.push_back(cur_v);
            cur_n = 0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00);
    endtask

    task automatic wait_pos(input int p);
        int k = 0;
        while ((m_t % 8) != p && k < 16) begin
            cyc(1'b0, 1'b0, 8'h00);
            k++;
        end
        if (k == 16) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_pos: position %0d not reached, at %0d", p, m_t % 8);
        end
    endtask

    task automatic chk_sym(input string name, input int idx, input logic [7:0] b, input logic vv);
        if (idx >= cap_b.size()) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: symbol %0d missing, only %0d captured", name, idx, cap_b.size());
        end else begin
            chk(name, {cap_v[idx], cap_b[idx]}, {vv, b});
        end
    endtask

    typedef struct {
        logic       rst;
        logic       v;
        logic [7:0] d;
        logic [4:0] exp;   // {data_out, symbol_start, valid_out, ready, overflow}
    } vec_t;

    vec_t tbl[12];

    initial begin
        int base;
        int dens;

        tbl[0]  = '{1'b1, 1'b0, 8'h00, 5'b00000};
        tbl[1]  = '{1'b1, 1'b0, 8'h00, 5'b00000};
        tbl[2]  = '{1'b0, 1'b0, 8'h00, 5'b11010};
        tbl[3]  = '{1'b0, 1'b0, 8'h00, 5'b00010};
        tbl[4]  = '{1'b0, 1'b0, 8'h00, 5'b10010};
        tbl[5]  = '{1'b0, 1'b0, 8'h00, 5'b10010};
        tbl[6]  = '{1'b0, 1'b0, 8'h00, 5'b10010};
        tbl[7]  = '{1'b0, 1'b0, 8'h00, 5'b10010};
        tbl[8]  = '{1'b0, 1'b0, 8'h00, 5'b00010};
        tbl[9]  = '{1'b0, 1'b0, 8'h00, 5'b00010};
        tbl[10] = '{1'b0, 1'b0, 8'h00, 5'b11010};
        tbl[11] = '{1'b0, 1'b0, 8'h00, 5'b00010};

        for (int i = 0; i < 12; i++) begin
            cyc(tbl[i].rst, tbl[i].v, tbl[i].d);
            chk($sformatf("vec%0d", i), {data_out, symbol_start, valid_out, ready, overflow}, tbl[i].exp);
        end

        // Idle after reset: four COM then IDL, never valid
        idle(47 - m_t);
        for (int i = 0; i < NSYNC; i++) chk_sym("sync_com", i, K_COM, 1'b0);
        chk_sym("idle_fill0", NSYNC, K_IDL, 1'b0);
        chk_sym("idle_fill1", NSYNC + 1, K_IDL, 1'b0);
        chk("no_ovf_idle", overflow, 0);

        // Byte written during SYNC is the first ACTIVE symbol
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
        idle(4);
        cyc(1'b0, 1'b1, 8'hA5);
        idle(47 - m_t);
        chk_sym("sync_write", NSYNC, 8'hA5, 1'b1);
        chk_sym("after_sync_write", NSYNC + 1, K_IDL, 1'b0);

        // Burst of six bytes: four fit, two dropped, overflow sticks
        wait_pos(0);
        base = cap_b.size();
        for (int i = 1; i <= 6; i++) begin
            cyc(1'b0, 1'b1, 8'(i));
            if (i == 4) chk("ready_full", ready, 0);
            if (i == 5) chk("ovf_set", overflow, 1);
        end
        idle(48);
        chk_sym("burst_idle", base, K_IDL, 1'b0);
        for (int i = 1; i <= 4; i++) chk_sym("burst_byte", base + i, 8'(i), 1'b1);
        chk_sym("burst_tail", base + 5, K_IDL, 1'b0);
        chk("ovf_sticky", overflow, 1);

        // Push and pop on the same boundary edge with three bytes queued
        wait_pos(0);
        base = cap_b.size();
        cyc(1'b0, 1'b1, 8'h11);
        cyc(1'b0, 1'b1, 8'h22);
        cyc(1'b0, 1'b1, 8'h33);
        wait_pos(7);
        cyc(1'b0, 1'b1, 8'h5A);
        chk("ready_pushpop", ready, 1);
        idle(48);
        chk_sym("pp_b0", base + 1, 8'h11, 1'b1);
        chk_sym("pp_b1", base + 2, 8'h22, 1'b1);
        chk_sym("pp_b2", base + 3, 8'h33, 1'b1);
        chk_sym("pp_b3", base + 4, 8'h5A, 1'b1);
        chk_sym("pp_tail", base + 5, K_IDL, 1'b0);

        // Write on a boundary into an empty FIFO waits one full symbol
        wait_pos(7);
        cyc(1'b0, 1'b1, 8'h3C);
        base = cap_b.size();
        idle(24);
        chk_sym("nobypass_idle", base, K_IDL, 1'b0);
        chk_sym("nobypass_byte", base + 1, 8'h3C, 1'b1);

        // Reset in the middle of a data symbol with two bytes still queued
        wait_pos(0);
        cyc(1'b0, 1'b1, 8'h41);
        cyc(1'b0, 1'b1, 8'h42);
        cyc(1'b0, 1'b1, 8'h43);
        wait_pos(0);
        chk("midrst_data", valid_out, 1);
        idle(3);
        cyc(1'b1, 1'b0, 8'h00);
        chk("midrst_zero", {data_out, symbol_start, valid_out, ready, overflow}, 0);
        cyc(1'b0, 1'b0, 8'h00);
        idle(47);
        for (int i = 0; i < NSYNC; i++) chk_sym("rerst_com", i, K_COM, 1'b0);
        chk_sym("rerst_idle0", NSYNC, K_IDL, 1'b0);
        chk_sym("rerst_idle1", NSYNC + 1, K_IDL, 1'b0);
        chk("rerst_ovf", overflow, 0);

        // Random traffic with occasional resets against the model
        dens = 50;
        for (int i = 0; i < 4000; i++) begin
            if (i % 200 == 0) dens = $urandom_range(10, 95);
            cyc(($urandom_range(0, 599) == 0), ($urandom_range(0, 99) < dens), 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
